// File: rtl/m_rom_arbiter_rr_if.sv
// Bundle of requester-side and memory-side signals around the ROM read arbiter.
// slave is the arbiter's view; master is the environment (requesters + memory).
interface m_rom_arbiter_rr_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            rd;
  logic [NUM_PORTS-1:0]            preempt;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0]            accept;
  logic [NUM_PORTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]           data;
  logic                            mem_rd;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_accept;
  logic [DATA_WIDTH-1:0]           mem_d4rd;

  modport slave (
    input  rd, preempt, addr, mem_accept, mem_d4rd,
    output accept, rvalid, data, mem_rd, mem_addr
  );

  modport master (
    output rd, preempt, addr, mem_accept, mem_d4rd,
    input  accept, rvalid, data, mem_rd, mem_addr
  );
endinterface

// File: rtl/m_rom_arbiter_rr.sv
// Shared ROM read-port arbiter: fixed-priority preemption over round-robin,
// with a fixed-latency return pipeline steering read data back to its port.
module m_rom_arbiter_rr #(
  parameter int NUM_PORTS   = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1,
  parameter int IDX_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  m_rom_arbiter_rr_if.slave bus
);

  logic [IDX_WIDTH-1:0]   ptr;
  logic [NUM_PORTS-1:0]   pre_req;
  logic                   pre_hit;
  logic                   grant_vld;
  logic [IDX_WIDTH-1:0]   grant_idx;
  logic [NUM_PORTS-1:0]   grant;
  logic                   take;
  logic [IDX_WIDTH:0]     rr_sel;
  logic [MEM_LATENCY-1:0] vld_p;
  logic [IDX_WIDTH-1:0]   idx_p [MEM_LATENCY];

  // Returns {found, index} of the first requester after p, wrapping at NUM_PORTS.
  function automatic logic [IDX_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [IDX_WIDTH-1:0] p);
    logic [IDX_WIDTH:0] r;
    int                 best;
    int                 d;
    r    = '0;
    best = NUM_PORTS;
    for (int i = 0; i < NUM_PORTS; i++) begin
      d = i - int'(p) - 1;
      if (d < 0) d = d + NUM_PORTS;
      if (req[i] && (d < best)) begin
        best = d;
        r    = {1'b1, IDX_WIDTH'(i)};
      end
    end
    return r;
  endfunction

  always_comb begin
    pre_req   = bus.rd & bus.preempt;
    pre_hit   = |pre_req;
    rr_sel    = rr_pick(bus.rd, ptr);
    grant_vld = 1'b0;
    grant_idx = '0;
    if (pre_hit) begin
      grant_vld = 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (pre_req[i]) grant_idx = IDX_WIDTH'(i);
      end
    end else if (rr_sel[IDX_WIDTH]) begin
      grant_vld = 1'b1;
      grant_idx = rr_sel[IDX_WIDTH-1:0];
    end
  end

  always_comb begin
    grant        = '0;
    bus.mem_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_vld && (grant_idx == IDX_WIDTH'(i))) begin
        grant[i]     = 1'b1;
        bus.mem_addr = bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign take       = grant_vld & bus.mem_accept & ~rst;
  assign bus.mem_rd = |bus.rd;
  assign bus.accept = grant & {NUM_PORTS{take}};
  assign bus.data   = bus.mem_d4rd;

  // Stage 0 captures the accepted read; later stages track the memory latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      ptr   <= IDX_WIDTH'(NUM_PORTS - 1);
    end else begin
      vld_p[0] <= take;
      for (int k = 1; k < MEM_LATENCY; k++) vld_p[k] <= vld_p[k-1];
      if (take && !pre_hit) ptr <= grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    idx_p[0] <= grant_idx;
    for (int k = 1; k < MEM_LATENCY; k++) idx_p[k] <= idx_p[k-1];
  end

  // Return stage: steer the shared data strobe to the owning port.
  always_comb begin
    bus.rvalid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.rvalid[i] = ~rst & vld_p[MEM_LATENCY-1] & (idx_p[MEM_LATENCY-1] == IDX_WIDTH'(i));
    end
  end

endmodule

// File: tb/tb_m_rom_arbiter_rr.sv
// Bench for m_rom_arbiter_rr: a 4-port/latency-2 and a 6-port/latency-3 instance,
// directed grant vectors plus a scoreboard for returned read data.
module tb_m_rom_arbiter_rr;
  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    int            port;
    logic [AW-1:0] a;
    int            due;
  } sb_t;

  logic clk = 1'b0;
  logic rst4, rst6;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  sb_t  q4[$];
  sb_t  q6[$];
  sb_t  e4, e6;
  logic [AW-1:0] a4 [4];
  logic [AW-1:0] a6 [6];
  logic [AW-1:0] m4 [2];
  logic [AW-1:0] m6 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_rom_arbiter_rr_if #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b4 ();
  m_rom_arbiter_rr_if #(.NUM_PORTS(6), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b6 ();

  m_rom_arbiter_rr #(.NUM_PORTS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MEM_LATENCY(2), .IDX_WIDTH(4))
    dut4 (.clk(clk), .rst(rst4), .bus(b4.slave));

  m_rom_arbiter_rr #(.NUM_PORTS(6), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .MEM_LATENCY(3), .IDX_WIDTH(3))
    dut6 (.clk(clk), .rst(rst6), .bus(b6.slave));

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  // Fixed-latency ROM models
  always @(posedge clk) begin
    m4[0] <= b4.mem_addr;
    m4[1] <= m4[0];
    m6[0] <= b6.mem_addr;
    m6[1] <= m6[0];
    m6[2] <= m6[1];
  end
  assign b4.mem_d4rd = rom(m4[1]);
  assign b6.mem_d4rd = rom(m6[2]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step4(input logic [3:0] rd, input logic [3:0] pre, input logic macc,
                       input int g, input string tag);
    logic [3:0] exp_acc;
    b4.rd = rd; b4.preempt = pre; b4.mem_accept = macc;
    @(negedge clk);
    exp_acc = (!rst4 && macc && g >= 0) ? 4'(1 << g) : 4'b0;
    chk({tag, " accept"}, b4.accept, exp_acc);
    chk({tag, " mem_addr"}, b4.mem_addr, (g >= 0) ? a4[g] : '0);
    chk({tag, " mem_rd"}, b4.mem_rd, |rd);
    if (exp_acc != 0) q4.push_back('{g, a4[g], cyc + 2});
    @(posedge clk); #1;
  endtask

  task automatic step6(input logic [5:0] rd, input logic macc, input int g,
                       input bit keep, input string tag);
    logic [5:0] exp_acc;
    b6.rd = rd; b6.preempt = '0; b6.mem_accept = macc;
    @(negedge clk);
    exp_acc = (!rst6 && macc && g >= 0) ? 6'(1 << g) : 6'b0;
    chk({tag, " accept"}, b6.accept, exp_acc);
    chk({tag, " mem_addr"}, b6.mem_addr, (g >= 0) ? a6[g] : '0);
    if (exp_acc != 0 && keep) q6.push_back('{g, a6[g], cyc + 3});
    @(posedge clk); #1;
  endtask

  // Return-path monitors
  always @(negedge clk) begin
    if (b4.rvalid != 0) begin
      if (q4.size() == 0) chk("rv4 unexpected", b4.rvalid, 0);
      else begin
        e4 = q4.pop_front();
        chk("rv4 port", b4.rvalid, 64'(1 << e4.port));
        chk("rv4 data", b4.data, rom(e4.a));
        chk("rv4 cycle", cyc, e4.due);
      end
    end
  end

  always @(negedge clk) begin
    if (b6.rvalid != 0) begin
      if (q6.size() == 0) chk("rv6 unexpected", b6.rvalid, 0);
      else begin
        e6 = q6.pop_front();
        chk("rv6 port", b6.rvalid, 64'(1 << e6.port));
        chk("rv6 data", b6.data, rom(e6.a));
        chk("rv6 cycle", cyc, e6.due);
      end
    end
  end

  initial begin
    rst4 = 1'b1; rst6 = 1'b1;
    b4.rd = '0; b4.preempt = '0; b4.mem_accept = 1'b1; b4.addr = '0;
    b6.rd = '0; b6.preempt = '0; b6.mem_accept = 1'b1; b6.addr = '0;
    for (int i = 0; i < 4; i++) begin
      a4[i] = AW'(10'h100 + i * 10'h011);
      b4.addr[i*AW +: AW] = a4[i];
    end
    for (int i = 0; i < 6; i++) begin
      a6[i] = AW'(10'h200 + i * 10'h005);
      b6.addr[i*AW +: AW] = a6[i];
    end
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset behaviour
    step4(4'b0000, 4'b0000, 1'b1, -1, "rst idle");
    chk("rst rvalid", b4.rvalid, 0);
    step4(4'b1111, 4'b0000, 1'b1, 0, "rst busy");
    rst4 = 1'b0;

    // all ports requesting: round robin 0,1,2,3,...
    for (int k = 0; k < 8; k++) step4(4'b1111, 4'b0000, 1'b1, k % 4, "rr all");
    for (int k = 0; k < 3; k++) step4(4'b0000, 4'b0000, 1'b1, -1, "idle");

    // preempt port 1 over port 3; ptr must stay at 3
    for (int k = 0; k < 3; k++) step4(4'b1010, 4'b0010, 1'b1, 1, "pre1");
    step4(4'b1010, 4'b0000, 1'b1, 1, "post pre a");
    step4(4'b1010, 4'b0000, 1'b1, 3, "post pre b");

    // two preempters: highest index wins
    step4(4'b0101, 4'b0101, 1'b1, 2, "pre02 a");
    step4(4'b0101, 4'b0101, 1'b1, 2, "pre02 b");
    step4(4'b0001, 4'b0001, 1'b1, 0, "pre0");
    step4(4'b0000, 4'b0000, 1'b1, -1, "idle");

    // memory stall holds everything
    for (int k = 0; k < 3; k++) step4(4'b0110, 4'b0000, 1'b0, 1, "stall");
    step4(4'b0110, 4'b0000, 1'b1, 1, "unstall 1");
    step4(4'b0100, 4'b0000, 1'b1, 2, "unstall 2");
    step4(4'b1111, 4'b0000, 1'b1, 3, "ptr was 2");
    step4(4'b0001, 4'b1110, 1'b1, 0, "pre no rd");
    step4(4'b1111, 4'b0000, 1'b1, 1, "ptr was 0");
    for (int k = 0; k < 4; k++) step4(4'b0000, 4'b0000, 1'b1, -1, "drain");

    // 6-port instance: reset discards an in-flight read
    rst6 = 1'b0;
    step6(6'b001000, 1'b1, 3, 1'b0, "d6 acc3");
    rst6 = 1'b1;
    step6(6'b000000, 1'b1, -1, 1'b0, "d6 rst");
    chk("d6 rst rvalid", b6.rvalid, 0);
    rst6 = 1'b0;
    step6(6'b101100, 1'b1, 2, 1'b1, "d6 first");

    // wrap-around from ptr=5
    step6(6'b100000, 1'b1, 5, 1'b1, "d6 p5");
    for (int k = 0; k < 7; k++) step6(6'b111111, 1'b1, k % 6, 1'b1, "d6 wrap");
    for (int k = 0; k < 5; k++) step6(6'b000000, 1'b1, -1, 1'b0, "d6 drain");

    chk("q4 drained", q4.size(), 0);
    chk("q6 drained", q6.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
